// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Shares the single RegisterFile write port between the main pipeline
// writeback and the multicycle (mul/div) unit.
// - The pipeline always wins the slot.
// - Multicycle results always pass through a small FIFO and are drained
//   whenever the pipeline leaves the slot free.
// - A 32-bit scoreboard marks registers that have an outstanding multicycle
//   write. Decode is stalled on RAW (rs/rt) or WAW (issue_rd) hits against it.
// - If the pipeline keeps a non-empty FIFO blocked for STARVE_LIMIT cycles,
//   pipe_hold asks the pipeline for a writeback bubble.
//
// Optional feature (macro SB_EARLY_CLR_EN):
//   defined   - a busy bit clears on the same edge its result is driven onto
//               the rf outputs (for a write-before-read RegisterFile).
//   undefined - a busy bit clears one edge later, when RegisterFile commits.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   pipe_we, pipe_rd, pipe_data  pipeline writeback request
//   mc_valid, mc_rd, mc_data     multicycle result (accepted when mc_ready)
//   mc_ready                     FIFO has room (from registered count only)
//   issue_mc, issue_rd           decode issuing a multicycle op and its rd
//   rs_chk, rt_chk               decode source registers to hazard-check
//   stall                        decode must hold (combinational)
//   pipe_hold                    request a pipeline writeback bubble
//   rf_we, rf_rd, rf_data        registered RegisterFile write port
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic        issue_mc,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs_chk,
  input  logic [4:0]  rt_chk,
  output logic        stall,
  output logic        pipe_hold,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0]    LIMIT_C  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FORCE
  } starve_state_e;

  // FIFO storage and control
  logic [4:0]    buf_rd_q   [DEPTH];
  logic [4:0]    buf_rd_d   [DEPTH];
  logic [31:0]   buf_data_q [DEPTH];
  logic [31:0]   buf_data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Scoreboard
  logic [31:0]   busy_q, busy_d;
`ifndef SB_EARLY_CLR_EN
  logic          clr_valid_q, clr_valid_d;
  logic [4:0]    clr_rd_q, clr_rd_d;
`endif

  // Registered write port
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_data_q, rf_data_d;

  // Starvation tracking
  starve_state_e state_q, state_d;
  logic [3:0]    starve_q, starve_d;

  logic          push;
  logic          pop;
  logic          set_busy;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // The pop happens whenever the pipeline leaves the slot free; a push needs
  // room measured before this edge, so a full FIFO never accepts even if it
  // is popping in the same cycle.
  always_comb begin
    mc_ready  = (count_q < DEPTH_C);
    push      = mc_valid & mc_ready;
    pop       = ~pipe_we & (count_q != '0);
    head_rd   = buf_rd_q[rd_ptr_q];
    head_data = buf_data_q[rd_ptr_q];
    stall     = busy_q[rs_chk] | busy_q[rt_chk] | (issue_mc & busy_q[issue_rd]);
    set_busy  = issue_mc & (issue_rd != 5'd0) & ~stall;
    pipe_hold = (state_q == ST_FORCE);
    rf_we     = rf_we_q;
    rf_rd     = rf_rd_q;
    rf_data   = rf_data_q;
  end

  always_comb begin
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (push) begin
      buf_rd_d[wr_ptr_q]   = mc_rd;
      buf_data_d[wr_ptr_q] = mc_data;
      wr_ptr_d             = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
  end

  // Writes to R0 still take the slot (and pop the FIFO) but never enable
  // the register file.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (pipe_we) begin
      rf_we_d   = (pipe_rd != 5'd0);
      rf_rd_d   = pipe_rd;
      rf_data_d = pipe_data;
    end else if (pop) begin
      rf_we_d   = (head_rd != 5'd0);
      rf_rd_d   = head_rd;
      rf_data_d = head_data;
    end
  end

  // The clear is applied before the set so a same-edge set on the same
  // register wins.
  always_comb begin
    busy_d = busy_q;
`ifdef SB_EARLY_CLR_EN
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
`else
    clr_valid_d = pop;
    clr_rd_d    = head_rd;
    if (clr_valid_q) begin
      busy_d[clr_rd_q] = 1'b0;
    end
`endif
    if (set_busy) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // In PEND the FIFO is non-empty, so a cycle without a pop is a cycle in
  // which the pipeline blocked it.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        starve_d = 4'd0;
        if (count_d != '0) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (count_d == '0) begin
          state_d  = ST_IDLE;
          starve_d = 4'd0;
        end else if (pop) begin
          starve_d = 4'd0;
        end else if (pipe_we) begin
          starve_d = starve_q + 4'd1;
          if (starve_d == LIMIT_C) begin
            state_d = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        if (pop) begin
          starve_d = 4'd0;
          state_d  = (count_d == '0) ? ST_IDLE : ST_PEND;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        starve_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
`ifndef SB_EARLY_CLR_EN
      clr_valid_q <= 1'b0;
      clr_rd_q    <= 5'd0;
`endif
      rf_we_q     <= 1'b0;
      rf_rd_q     <= 5'd0;
      rf_data_q   <= 32'd0;
      state_q     <= ST_IDLE;
      starve_q    <= 4'd0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
`ifndef SB_EARLY_CLR_EN
      clr_valid_q <= clr_valid_d;
      clr_rd_q    <= clr_rd_d;
`endif
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_data_q   <= rf_data_d;
      state_q     <= state_d;
      starve_q    <= starve_d;
    end
  end

  // FIFO contents are only meaningful below count, so they need no reset.
  always_ff @(posedge clock) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clock;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        issue_mc;
  logic [4:0]  issue_rd;
  logic [4:0]  rs_chk;
  logic [4:0]  rt_chk;
  logic        stall;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of pending results, a busy bit per register,
  // the pending commit-time clear, a blocked-cycle tally and the hold flag.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_busy;
  bit          m_pend_v;
  logic [4:0]  m_pend_rd;
  bit          m_hold;
  int          m_blocked;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          model_ok = 0;

  regfile_wb_scheduler #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .mc_valid  (mc_valid),
    .mc_rd     (mc_rd),
    .mc_data   (mc_data),
    .mc_ready  (mc_ready),
    .issue_mc  (issue_mc),
    .issue_rd  (issue_rd),
    .rs_chk    (rs_chk),
    .rt_chk    (rt_chk),
    .stall     (stall),
    .pipe_hold (pipe_hold),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data)
  );

  // Free-running 10-time-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic expStall();
    return m_busy[rs_chk] | m_busy[rt_chk] | (issue_mc & m_busy[issue_rd]);
  endfunction

  // Advance the model across one clock edge using the inputs now applied
  task automatic modelEdge();
    bit     ready, push, nonempty, popped, stl;
    entry_t e;
    e.rd = 5'd0;
    e.data = 32'd0;
    if (reset) begin
      mq.delete();
      m_busy    = '0;
      m_pend_v  = 0;
      m_pend_rd = 5'd0;
      m_hold    = 0;
      m_blocked = 0;
      m_we      = 1'b0;
      m_rd      = 5'd0;
      m_data    = 32'd0;
      model_ok  = 1;
    end else begin
      ready    = (mq.size() < DEPTH);
      push     = mc_valid && ready;
      nonempty = (mq.size() != 0);
      stl      = expStall();
      popped   = !pipe_we && nonempty;
      if (popped) e = mq.pop_front();
`ifdef SB_EARLY_CLR_EN
      if (popped) m_busy[e.rd] = 1'b0;
`else
      if (m_pend_v) m_busy[m_pend_rd] = 1'b0;
`endif
      if (issue_mc && issue_rd != 5'd0 && !stl) m_busy[issue_rd] = 1'b1;
      m_pend_v  = popped;
      m_pend_rd = e.rd;
      if (pipe_we) begin
        m_we   = (pipe_rd != 5'd0);
        m_rd   = pipe_rd;
        m_data = pipe_data;
      end else if (popped) begin
        m_we   = (e.rd != 5'd0);
        m_rd   = e.rd;
        m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (push) mq.push_back('{rd: mc_rd, data: mc_data});
      if (popped) begin
        m_blocked = 0;
        m_hold    = 0;
      end else if (pipe_we && nonempty && !m_hold) begin
        m_blocked++;
        if (m_blocked == STARVE_LIMIT) m_hold = 1;
      end
      if (mq.size() == 0) begin
        m_blocked = 0;
        m_hold    = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, compare combinational outputs before the edge
  // and registered outputs just after it
  task automatic applyStimulus(input logic rst, input logic pwe, input logic [4:0] prd,
                               input logic [31:0] pdata, input logic mv,
                               input logic [4:0] mrd, input logic [31:0] mdata,
                               input logic imc, input logic [4:0] ird,
                               input logic [4:0] rs, input logic [4:0] rt);
    reset = rst; pipe_we = pwe; pipe_rd = prd; pipe_data = pdata;
    mc_valid = mv; mc_rd = mrd; mc_data = mdata;
    issue_mc = imc; issue_rd = ird; rs_chk = rs; rt_chk = rt;
    #1;
    if (model_ok) begin
      checkOutput("mc_ready", {31'd0, mc_ready}, {31'd0, (mq.size() < DEPTH)});
      checkOutput("stall", {31'd0, stall}, {31'd0, expStall()});
    end
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    checkOutput("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
    checkOutput("rf_data", rf_data, m_data);
    checkOutput("pipe_hold", {31'd0, pipe_hold}, {31'd0, m_hold});
  endtask

  task automatic idleCycle(input logic [4:0] rs);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, rs, 0);
  endtask

  // Directed scenarios first, then a randomized run against the model
  initial begin
    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("rst_ready", {31'd0, mc_ready}, 32'd1);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);

    // Pipeline only
    applyStimulus(0, 1, 5'd2, 32'hDEEDDEED, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("po_we", {31'd0, rf_we}, 32'd1);
    checkOutput("po_rd", {27'd0, rf_rd}, 32'd2);
    checkOutput("po_data", rf_data, 32'hDEEDDEED);
    idleCycle(0);
    checkOutput("po_we_off", {31'd0, rf_we}, 32'd0);
    checkOutput("po_rd_hold", {27'd0, rf_rd}, 32'd2);

    // Multicycle flow with RAW stall on r5
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd5, 32'hAAAADDDD, 0, 0, 5'd5, 0);
    checkOutput("mc_stall_busy", {31'd0, stall}, 32'd1);
    checkOutput("mc_not_yet", {31'd0, rf_we}, 32'd0);
    idleCycle(5'd5);
    checkOutput("mc_we", {31'd0, rf_we}, 32'd1);
    checkOutput("mc_rd", {27'd0, rf_rd}, 32'd5);
    checkOutput("mc_data", rf_data, 32'hAAAADDDD);
`ifdef SB_EARLY_CLR_EN
    checkOutput("mc_stall_present", {31'd0, stall}, 32'd0);
`else
    checkOutput("mc_stall_present", {31'd0, stall}, 32'd1);
`endif
    idleCycle(5'd5);
    checkOutput("mc_stall_commit", {31'd0, stall}, 32'd0);

    // Full FIFO while the pipeline holds the slot, then drain in order
    applyStimulus(0, 1, 5'd1, 32'h11, 1, 5'd10, 32'hA1, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd1, 32'h12, 1, 5'd11, 32'hA2, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd1, 32'h13, 1, 5'd12, 32'hA3, 0, 0, 0, 0);
    checkOutput("full_ready", {31'd0, mc_ready}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd12, 32'hA3, 0, 0, 0, 0);
    checkOutput("fifo_first", {27'd0, rf_rd}, 32'd10);
    applyStimulus(0, 0, 0, 0, 1, 5'd12, 32'hA3, 0, 0, 0, 0);
    checkOutput("fifo_second", {27'd0, rf_rd}, 32'd11);
    idleCycle(0);
    checkOutput("fifo_third", {27'd0, rf_rd}, 32'd12);
    checkOutput("fifo_third_data", rf_data, 32'hA3);
    idleCycle(0);

    // Starvation: one buffered entry blocked for STARVE_LIMIT cycles
    applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h55, 0, 0, 0, 0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      applyStimulus(0, 1, 5'd4, 32'h40 + i, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("starve_hold", {31'd0, pipe_hold}, (i == STARVE_LIMIT - 1) ? 32'd1 : 32'd0);
    end
    idleCycle(0);
    checkOutput("starve_release", {31'd0, pipe_hold}, 32'd0);
    checkOutput("starve_pop_rd", {27'd0, rf_rd}, 32'd3);

    // Writes to R0 never enable the register file or mark busy
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h1234, 1, 5'd0, 0, 0);
    idleCycle(0);
    checkOutput("r0_we", {31'd0, rf_we}, 32'd0);
    checkOutput("r0_stall", {31'd0, stall}, 32'd0);

    // Set and clear of r7 on the same edge: the set wins
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 0, 0);
`ifndef SB_EARLY_CLR_EN
    idleCycle(0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    idleCycle(5'd7);
    checkOutput("set_wins", {31'd0, stall}, 32'd1);

    // Reset with two entries buffered
    applyStimulus(0, 1, 5'd1, 32'h1, 1, 5'd8, 32'h88, 0, 0, 5'd7, 0);
    applyStimulus(0, 1, 5'd1, 32'h2, 1, 5'd9, 32'h99, 0, 0, 5'd7, 0);
    checkOutput("pre_rst_ready", {31'd0, mc_ready}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checkOutput("mid_rst_ready", {31'd0, mc_ready}, 32'd1);
    checkOutput("mid_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("mid_rst_we", {31'd0, rf_we}, 32'd0);
    idleCycle(5'd7);
    checkOutput("post_rst_we", {31'd0, rf_we}, 32'd0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 55),
                    5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 99) < 50),
                    5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 99) < 35),
                    5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of RegisterFile between two producers:
  - the main pipeline writeback, which has priority and never stalls;
  - the multicycle unit (mul/div) results, which are buffered.
- Keeps a 32-entry scoreboard of registers with outstanding multicycle writes and raises a decode stall on RAW/WAW hazards against them.
- Sits between the writeback stage, the multicycle unit, decode and RegisterFile's writeBackData/rdIn/RWE inputs.

Parameters:
- DEPTH, 2: multicycle result buffer entries (1..4).
- STARVE_LIMIT, 4: consecutive cycles a non-empty buffer may be blocked before pipe_hold is asserted (1..15).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline writeback data.
- mc_valid  in  1  multicycle result valid.
- mc_rd  in  5  multicycle destination register.
- mc_data  in  32  multicycle result.
- mc_ready  out  1  buffer can accept a result.
- issue_mc  in  1  decode is issuing a multicycle op this cycle.
- issue_rd  in  5  destination of the issuing multicycle op.
- rs_chk  in  5  decode rs.
- rt_chk  in  5  decode rt.
- stall  out  1  decode must hold.
- pipe_hold  out  1  request to the pipeline to bubble writeback next cycle.
- rf_we  out  1  register file write enable (drives RWE).
- rf_rd  out  5  register file write address.
- rf_data  out  32  register file write data.

Behaviour:
- Reset (clock edge with reset=1):
  - rf_we=0, rf_rd=0, rf_data=0, pipe_hold=0.
  - Buffer empty, all busy bits 0, starve counter 0, state IDLE.
  - After reset, mc_ready=1 and stall=0.
  - Reset asserted mid-operation discards all buffered results and busy bits.
- Write slot, one per cycle, decided at each edge with all outputs registered:
  - If pipe_we=1: rf_we<=1, rf_rd<=pipe_rd, rf_data<=pipe_data.
  - Else if the buffer is non-empty: pop the head and present it on the rf outputs.
  - Else rf_we<=0; rf_rd and rf_data hold their previous values.
- Latency:
  - A pipeline write is on the rf outputs in the cycle after it is sampled.
  - A multicycle result accepted at edge N is presented no earlier than after edge N+1. It always passes through the buffer; there is no same-cycle pass-through.
- R0:
  - Any write to rd=0, from either source, gives rf_we<=0 but still consumes the slot/pop.
  - R0 is never marked busy.
- Handshake:
  - mc_ready = (count < DEPTH), derived from registered count only.
  - A transfer occurs when mc_valid & mc_ready.
  - A push and a pop in the same cycle keep count unchanged.
  - When full, mc_ready=0 even if a pop occurs that cycle.
  - Buffer order is FIFO; read/write pointers wrap modulo DEPTH.
- Scoreboard:
  - issue_mc=1 with issue_rd≠0 and stall=0 sets busy[issue_rd] at the edge.
  - A popped entry clears busy[rd] at the edge after it appears on the rf outputs, i.e. the edge at which RegisterFile commits it.
  - If a set and a clear hit the same register on the same edge, the set wins.
- Stall:
  - stall = busy[rs_chk] | busy[rt_chk] | (issue_mc & busy[issue_rd]).
  - The last term is the WAW check.
  - Index 0 never stalls.
  - stall is combinational from registered busy bits.
- A pipeline write to a busy register is still performed; its busy bit is unchanged.
- Starvation FSM:
  - IDLE (buffer empty)
    - -> PEND when count becomes non-zero.
  - PEND
    - counter increments each cycle pipe_we=1 blocks a non-empty buffer;
    - counter resets to 0 on any pop;
    - -> FORCE when counter == STARVE_LIMIT;
    - -> IDLE when empty.
  - FORCE
    - pipe_hold=1;
    - on the next pop -> PEND (counter 0), or -> IDLE if the buffer is then empty.
    - If pipe_we arrives anyway while in FORCE, the pipeline still wins; stay in FORCE.

Optional Feature:
- Macro: SB_EARLY_CLR_EN.
- Defined: busy[rd] clears on the same edge the entry is driven onto the rf outputs, one cycle earlier than baseline. Use with a write-before-read RegisterFile.
- Undefined: baseline clear timing as above.

Test Plan:
- Pipeline only:
  - Stimulus: pipe_we=1, rd=2, data=32'hDEEDDEED at edge 1.
  - Response: rf_we=1, rf_rd=2, rf_data=DEEDDEED after edge 1; rf_we=0 after edge 2 with pipe_we=0.
- Multicycle flow:
  - Stimulus: issue_mc rd=5; then mc_valid rd=5, data=32'hAAAADDDD with pipe idle; decode rs_chk=5.
  - Response: busy[5] set; stall=1 with rs_chk=5; result on rf outputs 1 cycle after acceptance; stall drops 1 cycle later (same cycle with SB_EARLY_CLR_EN).
- Full buffer:
  - Stimulus: DEPTH=2, pipe_we held 1, three mc_valid results.
  - Response: first two accepted; mc_ready=0 on the third until a pop.
  - Then drop pipe_we: results written in FIFO order on consecutive cycles.
- Starvation:
  - Stimulus: buffer holds one entry; pipe_we=1 for 4 cycles.
  - Response: pipe_hold=1 after the 4th blocked cycle; cleared after the pop when pipe_we=0.
- Edges:
  - Stimulus: mc write to rd=0; separately, issue_mc rd=7 in the same cycle the rd=7 entry clears; then reset asserted with 2 entries buffered.
  - Response:
    - rd=0 write: rf_we=0 and no busy bit set.
    - Same-cycle set/clear: busy[7] remains 1.
    - Reset: count=0, mc_ready=1, stall=0, rf_we=0 next cycle.
